// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between the commit stage and the CSR file.
//
// Takes synchronous exceptions, external/timer interrupts and MRET, then runs a
// fixed sequence: one strobe cycle (TRAP or MRET), then a redirect to fetch
// that is held until fetch accepts it.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_e_irq, i_t_irq      raw level interrupt lines (synchronised internally)
//   i_mie/i_meie/i_mtie   global and per-source interrupt enables from the CSR file
//   i_excep_*             exception valid/cause/PC at the commit stage
//   i_mret_valid          MRET at the commit stage
//   i_commit_valid/_npc   retiring instruction and its successor PC (interrupt boundary)
//   i_pc_trap             trap vector from the CSR file, combinational from our strobes
//   i_mepc                saved return PC from the CSR file
//   i_redirect_ready      fetch accepts the redirect
//   o_intr_en/o_excep_en  trap-entry strobes with o_intr_cause/o_excep_cause/o_trap_pc
//   o_mret                MRET strobe
//   o_flush               kill in-flight instructions
//   o_redirect_valid/_pc  redirect request to fetch
//   o_busy                sequencer is not idle
module trap_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] MEI_CAUSE   = 4'd11,
  parameter logic [3:0] MTI_CAUSE   = 4'd7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_e_irq,
  input  logic        i_t_irq,
  input  logic        i_mie,
  input  logic        i_meie,
  input  logic        i_mtie,
  input  logic        i_excep_valid,
  input  logic [3:0]  i_excep_cause,
  input  logic [31:0] i_excep_pc,
  input  logic        i_mret_valid,
  input  logic        i_commit_valid,
  input  logic [31:0] i_commit_npc,
  input  logic [31:0] i_pc_trap,
  input  logic [31:0] i_mepc,
  input  logic        i_redirect_ready,
  output logic        o_intr_en,
  output logic        o_excep_en,
  output logic [3:0]  o_intr_cause,
  output logic [3:0]  o_excep_cause,
  output logic [31:0] o_trap_pc,
  output logic        o_mret,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAP  = 2'd1;
  localparam logic [1:0] ST_MRET  = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

  logic [SYNC_STAGES-1:0] e_sync_q, e_sync_d;
  logic [SYNC_STAGES-1:0] t_sync_q, t_sync_d;
  logic [1:0]  state_q, state_d;
  logic        intr_en_q, intr_en_d;
  logic        excep_en_q, excep_en_d;
  logic [3:0]  intr_cause_q, intr_cause_d;
  logic [3:0]  excep_cause_q, excep_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        mret_q, mret_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  logic e_s, t_s, irq_ext_s, irq_tmr_s, irq_pend_s;
  logic [3:0] irq_cause_s;

  // Shift chains that bring the raw interrupt levels into the clock domain.
  always_comb begin
    e_sync_d    = e_sync_q;
    t_sync_d    = t_sync_q;
    e_sync_d[0] = i_e_irq;
    t_sync_d[0] = i_t_irq;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      e_sync_d[i] = e_sync_q[i-1];
      t_sync_d[i] = t_sync_q[i-1];
    end
  end

  assign e_s         = e_sync_q[SYNC_STAGES-1];
  assign t_s         = t_sync_q[SYNC_STAGES-1];
  assign irq_ext_s   = e_s & i_meie;
  assign irq_tmr_s   = t_s & i_mtie;
  assign irq_pend_s  = i_mie & (irq_ext_s | irq_tmr_s);
  // External interrupt wins over timer when both are enabled and pending.
  assign irq_cause_s = irq_ext_s ? MEI_CAUSE : MTI_CAUSE;

  // Next-state and next-output logic; outputs are registered off the next state,
  // so the strobe appears the cycle after the event and redirect one cycle later.
  always_comb begin
    state_d          = state_q;
    intr_en_d        = 1'b0;
    excep_en_d       = 1'b0;
    intr_cause_d     = 4'd0;
    excep_cause_d    = 4'd0;
    trap_pc_d        = 32'd0;
    mret_d           = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (i_excep_valid) begin
          state_d       = ST_TRAP;
          excep_en_d    = 1'b1;
          excep_cause_d = i_excep_cause;
          trap_pc_d     = i_excep_pc;
          flush_d       = 1'b1;
        end else if (i_mret_valid) begin
          state_d = ST_MRET;
          mret_d  = 1'b1;
          flush_d = 1'b1;
        end else if (irq_pend_s && i_commit_valid) begin
          // Interrupts are only taken on a retirement so mepc is a precise resume point.
          state_d      = ST_TRAP;
          intr_en_d    = 1'b1;
          intr_cause_d = irq_cause_s;
          trap_pc_d    = i_commit_npc;
          flush_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        // i_pc_trap is valid now because the CSR file sees our entry strobe this cycle.
        state_d          = ST_REDIR;
        redirect_pc_d    = i_pc_trap;
        redirect_valid_d = 1'b1;
      end
      ST_MRET: begin
        state_d          = ST_REDIR;
        redirect_pc_d    = i_mepc;
        redirect_valid_d = 1'b1;
      end
      ST_REDIR: begin
        if (i_redirect_ready) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
        end else begin
          state_d          = ST_REDIR;
          redirect_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, synchroniser and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      e_sync_q         <= '0;
      t_sync_q         <= '0;
      state_q          <= ST_IDLE;
      intr_en_q        <= 1'b0;
      excep_en_q       <= 1'b0;
      intr_cause_q     <= 4'd0;
      excep_cause_q    <= 4'd0;
      trap_pc_q        <= 32'd0;
      mret_q           <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      busy_q           <= 1'b0;
    end else begin
      e_sync_q         <= e_sync_d;
      t_sync_q         <= t_sync_d;
      state_q          <= state_d;
      intr_en_q        <= intr_en_d;
      excep_en_q       <= excep_en_d;
      intr_cause_q     <= intr_cause_d;
      excep_cause_q    <= excep_cause_d;
      trap_pc_q        <= trap_pc_d;
      mret_q           <= mret_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign o_intr_en        = intr_en_q;
  assign o_excep_en       = excep_en_q;
  assign o_intr_cause     = intr_cause_q;
  assign o_excep_cause    = excep_cause_q;
  assign o_trap_pc        = trap_pc_q;
  assign o_mret           = mret_q;
  assign o_flush          = flush_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_busy           = busy_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting between the pipeline and the CSR file.
- Arbitrates synchronous exceptions, external/timer interrupts and MRET.
- Drives the CSR trap-entry strobes (intr_en/excep_en, causes, trap PC) and the mret strobe.
- Flushes the pipeline and hands the new fetch PC to the fetch stage over a valid/ready redirect handshake.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each raw IRQ line (min 1)
MEI_CAUSE, 4'd11, mcause code for machine external interrupt
MTI_CAUSE, 4'd7, mcause code for machine timer interrupt

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_e_irq  in  1  raw external interrupt, level
i_t_irq  in  1  raw timer interrupt, level
i_mie  in  1  CSR mstatus.MIE
i_meie  in  1  CSR mie.MEIE
i_mtie  in  1  CSR mie.MTIE
i_excep_valid  in  1  exception at the commit stage
i_excep_cause  in  4  exception code
i_excep_pc  in  32  PC of the faulting instruction
i_mret_valid  in  1  MRET at the commit stage
i_commit_valid  in  1  instruction retiring this cycle (interrupt boundary)
i_commit_npc  in  32  PC of the next instruction after the retiring one
i_pc_trap  in  32  CSR trap-vector output (combinational from the strobes)
i_mepc  in  32  CSR mepc
i_redirect_ready  in  1  fetch accepts redirect
o_intr_en  out  1  CSR interrupt-entry strobe
o_excep_en  out  1  CSR exception-entry strobe
o_intr_cause  out  4  interrupt cause to CSR
o_excep_cause  out  4  exception cause to CSR
o_trap_pc  out  32  PC written into mepc by the CSR
o_mret  out  1  CSR mret strobe
o_flush  out  1  kill all in-flight instructions
o_redirect_valid  out  1  redirect PC valid
o_redirect_pc  out  32  new fetch PC
o_busy  out  1  state != IDLE

Behaviour:
- Reset: i_rst_n sampled on the i_clk edge. Reset is synchronous, active-low, on clock i_clk.
  - All outputs 0, state IDLE, sync flops 0.
  - Reset in any state aborts the sequence with no strobe and no redirect.
- IRQ synchronisation: e_s/t_s = i_e_irq/i_t_irq delayed SYNC_STAGES cycles.
- Pending interrupt: irq_pend = i_mie & ((e_s & i_meie) | (t_s & i_mtie)).
  - External has priority over timer: cause = MEI_CAUSE if (e_s & i_meie), else MTI_CAUSE.
- States: IDLE, TRAP, MRET, REDIRECT.
- IDLE transitions, priority order:
  1. i_excep_valid -> TRAP(excep). Latch cause = i_excep_cause, tpc = i_excep_pc.
  2. Else i_mret_valid -> MRET.
  3. Else irq_pend & i_commit_valid -> TRAP(intr). Latch cause, tpc = i_commit_npc.
  4. Otherwise stay in IDLE.
- TRAP: exactly one cycle.
  - o_excep_en or o_intr_en = 1, with the matching cause and o_trap_pc = tpc (other cause output 0).
  - o_flush = 1.
  - Capture i_pc_trap into o_redirect_pc.
  - Next state REDIRECT.
- MRET: exactly one cycle.
  - o_mret = 1, o_flush = 1.
  - Capture i_mepc into o_redirect_pc.
  - Next state REDIRECT.
- REDIRECT:
  - o_redirect_valid = 1; o_redirect_pc held stable.
  - On i_redirect_ready -> IDLE. Ready is sampled the same cycle; one-cycle minimum.
- Outputs are registered from state.
  - Event sampled at edge t; strobe visible cycle t+1; redirect valid from t+2.
  - Fixed latency: event -> redirect_valid = 2 cycles.
- While not IDLE, i_excep_valid, i_mret_valid, i_commit_valid and irq changes are ignored; the pipeline is flushed.
  - A level interrupt still asserted is re-evaluated in IDLE. After trap entry the CSR clears MIE, so there is no re-entry until the handler re-enables it.
- Exception and interrupt in the same cycle: the exception is taken. The interrupt stays pending (level) and is not lost.
- Exception and MRET in the same cycle: the exception is taken.
- Interrupt with i_commit_valid = 0: wait in IDLE; no trap.
- i_mie deasserted in the same cycle as an IRQ: no trap.
- At most one strobe (intr_en/excep_en/mret) is asserted in any cycle; the strobes are mutually exclusive.
- Back-to-back: an event arriving in the cycle REDIRECT completes is taken next cycle (IDLE samples it).

Test Plan:
- Reset: hold i_rst_n = 0 with all inputs active -> every output 0, o_busy = 0.
- Exception: CSR mtvec = 0x100 direct; i_excep_valid, cause = 2, pc = 0x40 -> o_excep_en one cycle with o_trap_pc = 0x40, o_flush; o_redirect_pc = 0x100, valid until ready; mcause = 2, mepc = 0x40.
- Vectored MEI: mtvec = 0x101, MIE = 1, MEIE = 1; assert i_e_irq with i_commit_valid, npc = 0x88 -> after SYNC_STAGES, o_intr_en, cause 11; redirect 0x12C; mepc = 0x88; then mstatus.MIE = 0.
- Priority: e_irq and t_irq with both enables plus i_excep_valid cause 5 in the same cycle -> exception taken (cause 5). After return, MEI (11) is taken before MTI (7).
- MRET: mepc = 0x200, i_mret_valid -> o_mret one cycle, o_redirect_pc = 0x200. Hold i_redirect_ready = 0 for 3 cycles -> valid and PC stable; IDLE one cycle after ready.
- Reset mid-sequence: reset asserted in REDIRECT -> o_redirect_valid drops next edge, IDLE, no further strobes.
